// File: rtl/nonce_hub_arbiter.sv
// nonce_hub_arbiter
//   Collects golden-nonce strobes from SLAVES sources into one held register per
//   source. It arbitrates those registers into a shared FIFO and feeds
//   serial_transmit one word at a time.
//
// Ports
//   hash_clk      sole clock
//   reset_n       asynchronous active-low reset
//   slave_nonces  nonce of slave i at [i*32+31:i*32]
//   new_nonces    one-cycle strobe per slave, qualifies its slave_nonces slice
//   serial_busy   transmitter busy
//   serial_send   send request to the transmitter
//   golden_nonce  word currently offered / last word sent
//   fifo_count    FIFO occupancy, 0..2**FIFO_DEPTH_LOG2
//   overflow      sticky, set when any held nonce is overwritten unsent
//   drop_count    saturating count of overwritten nonces
//   last_slave    source index of the word most recently popped for sending
//
// Transmit handshake (send/busy):
//   serial_send rises with golden_nonce/last_slave already valid. Both stay
//   stable until serial_busy=1 is sampled, and then serial_send drops. No new
//   word is offered until serial_busy has been sampled low again from DRAIN,
//   and a pop also needs serial_busy=0 in IDLE.
//   The internal tx state is in 'state' (IDLE/REQ/DRAIN) for checker binding.
module nonce_hub_arbiter #(
  parameter int SLAVES          = 4,
  parameter int FIFO_DEPTH_LOG2 = 3,
  parameter int ARB_MODE        = 0,
  parameter int SID_W           = 5
) (
  input  logic                       hash_clk,
  input  logic                       reset_n,
  input  logic [SLAVES*32-1:0]       slave_nonces,
  input  logic [SLAVES-1:0]          new_nonces,
  input  logic                       serial_busy,
  output logic                       serial_send,
  output logic [31:0]                golden_nonce,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_count,
  output logic                       overflow,
  output logic [15:0]                drop_count,
  output logic [SID_W-1:0]           last_slave
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int FW    = 32 + SID_W;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DRAIN = 2'd2} tx_state_t;
  tx_state_t state, state_nx;

  logic [31:0]                held [SLAVES];
  logic [SLAVES-1:0]          pending;
  logic [SID_W-1:0]           rr_ptr;

  logic                       found;
  logic                       grant_vld;
  logic [SID_W-1:0]           grant_idx;
  logic [31:0]                grant_data;
  logic [5:0]                 drop_n;
  logic [16:0]                drop_sum;

  logic [FW-1:0]              mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic                       fifo_full, fifo_empty;
  logic                       push, pop;

  // Full comes from the registered count. A pop in this cycle does not free
  // a slot for a push in the same cycle.
  assign fifo_full  = (fifo_count == (FIFO_DEPTH_LOG2+1)'(DEPTH));
  assign fifo_empty = (fifo_count == '0);

  // Arbiter. The first pass only accepts indices at or above the round-robin
  // pointer, and the second pass wraps around to the lower ones. In
  // fixed-priority mode the first pass accepts every index, so the lowest
  // pending index wins.
  always_comb begin
    found      = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
    for (int i = 0; i < SLAVES; i++) begin
      if (!found && pending[i] && (ARB_MODE != 0 || i >= int'(rr_ptr))) begin
        found      = 1'b1;
        grant_idx  = SID_W'(i);
        grant_data = held[i];
      end
    end
    for (int i = 0; i < SLAVES; i++) begin
      if (!found && pending[i]) begin
        found      = 1'b1;
        grant_idx  = SID_W'(i);
        grant_data = held[i];
      end
    end
    grant_vld = found && !fifo_full;
  end

  // A re-strobe of a pending slot is a loss unless that slot is being granted
  // this cycle. In that case the old value leaves through the FIFO.
  always_comb begin
    drop_n = '0;
    for (int i = 0; i < SLAVES; i++) begin
      if (new_nonces[i] && pending[i] && !(grant_vld && grant_idx == SID_W'(i)))
        drop_n = drop_n + 6'd1;
    end
    drop_sum = {1'b0, drop_count} + 17'(drop_n);
  end

  assign push = grant_vld;
  assign pop  = (state == IDLE) && !fifo_empty && !serial_busy;

  // Capture stage and arbitration pointer
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
      rr_ptr  <= '0;
      for (int i = 0; i < SLAVES; i++) held[i] <= '0;
    end else begin
      for (int i = 0; i < SLAVES; i++) begin
        if (new_nonces[i]) begin
          held[i]    <= slave_nonces[i*32 +: 32];
          pending[i] <= 1'b1;
        end else if (grant_vld && grant_idx == SID_W'(i)) begin
          pending[i] <= 1'b0;
        end
      end
      if (grant_vld)
        rr_ptr <= (grant_idx == SID_W'(SLAVES-1)) ? '0 : grant_idx + SID_W'(1);
    end
  end

  // Loss reporting
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (drop_n != '0) overflow <= 1'b1;
    end
  end

  // FIFO storage. Reset is not needed because occupancy guards every read.
  always_ff @(posedge hash_clk) begin
    if (push) mem[wr_ptr] <= {grant_idx, grant_data};
  end

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_DEPTH_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_DEPTH_LOG2'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (FIFO_DEPTH_LOG2+1)'(1);
        2'b01:   fifo_count <= fifo_count - (FIFO_DEPTH_LOG2+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Transmit FSM
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      golden_nonce <= '0;
      last_slave   <= '0;
    end else begin
      state <= state_nx;
      if (pop) {last_slave, golden_nonce} <= mem[rd_ptr];
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pop)          state_nx = REQ;
      REQ:     if (serial_busy)  state_nx = DRAIN;
      DRAIN:   if (!serial_busy) state_nx = IDLE;
      default:                   state_nx = IDLE;
    endcase
  end

  // serial_send comes from the state register, so reset drops it at once.
  assign serial_send = (state == REQ);

endmodule

// File: tb/tb_nonce_hub_arbiter.sv
// Bench for nonce_hub_arbiter. Instance dut0 uses round-robin mode with a
// transmitter model that can also hold busy. Instance dut1 uses fixed-priority
// mode with a minimal busy echo and only sees strobes in the ordering test.
module tb_nonce_hub_arbiter;

  localparam int SLAVES = 4;
  localparam int FL     = 3;
  localparam int SID_W  = 5;
  localparam int W      = 32 + SID_W;

  // ---------------- clock / reset ----------------
  logic hash_clk = 1'b0;
  logic reset_n  = 1'b1;
  always #5 hash_clk = ~hash_clk;

  logic [SLAVES*32-1:0] slave_nonces = '0;
  logic [SLAVES-1:0]    new_nonces   = '0;
  logic [SLAVES-1:0]    new_nonces1  = '0;
  logic                 busy0 = 1'b0, busy1 = 1'b0;

  logic             send0, send1;
  logic [31:0]      golden0, golden1;
  logic [FL:0]      count0, count1;
  logic             ovf0, ovf1;
  logic [15:0]      drop0, drop1;
  logic [SID_W-1:0] last0, last1;

  nonce_hub_arbiter #(.SLAVES(SLAVES), .FIFO_DEPTH_LOG2(FL), .ARB_MODE(0), .SID_W(SID_W)) dut0 (
    .hash_clk(hash_clk), .reset_n(reset_n), .slave_nonces(slave_nonces),
    .new_nonces(new_nonces), .serial_busy(busy0), .serial_send(send0),
    .golden_nonce(golden0), .fifo_count(count0), .overflow(ovf0),
    .drop_count(drop0), .last_slave(last0));

  nonce_hub_arbiter #(.SLAVES(SLAVES), .FIFO_DEPTH_LOG2(FL), .ARB_MODE(1), .SID_W(SID_W)) dut1 (
    .hash_clk(hash_clk), .reset_n(reset_n), .slave_nonces(slave_nonces),
    .new_nonces(new_nonces1), .serial_busy(busy1), .serial_send(send1),
    .golden_nonce(golden1), .fifo_count(count1), .overflow(ovf1),
    .drop_count(drop1), .last_slave(last1));

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_q1[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int n_send0 = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- transmitter models + output monitors ----------------
  int   busy_cnt  = 0;
  logic hold_busy = 1'b0;
  logic model_en  = 1'b1;
  logic prev0 = 1'b0, prev1 = 1'b0;

  always @(negedge hash_clk) begin
    if (send0 && !prev0) begin
      n_send0++;
      check("dut0_send_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("dut0_tx_word", 64'({last0, golden0}), 64'(exp_q.pop_front()));
    end
    prev0 = send0;
    if (!reset_n)                 busy_cnt = 0;
    else if (busy_cnt > 0)        busy_cnt--;
    else if (model_en && send0)   busy_cnt = 10;
    busy0 = hold_busy || (busy_cnt > 0);

    if (send1 && !prev1) begin
      check("dut1_send_expected", 64'(exp_q1.size() != 0), 64'd1);
      if (exp_q1.size() != 0) check("dut1_tx_word", 64'({last1, golden1}), 64'(exp_q1.pop_front()));
    end
    prev1 = send1;
    busy1 = send1;
  end

  // ---------------- driver tasks ----------------
  function automatic logic [SLAVES*32-1:0] slice(input int s, input logic [31:0] v);
    logic [SLAVES*32-1:0] d;
    d = '0;
    d[s*32 +: 32] = v;
    return d;
  endfunction

  // Presents the strobe through one rising edge and returns 1 ns after it.
  task automatic strobe(input logic [SLAVES-1:0] mask, input logic [SLAVES*32-1:0] data);
    new_nonces   = mask;
    slave_nonces = data;
    @(posedge hash_clk); #1;
    new_nonces = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge hash_clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    int cyc;
    cyc = 0;
    while (cyc < 3000 && !(exp_q.size() == 0 && exp_q1.size() == 0 && !send0 && !busy0 &&
                           count0 == 0 && !send1 && count1 == 0)) begin
      @(negedge hash_clk);
      cyc++;
    end
    check({tag, "_drain_in_budget"}, 64'(cyc < 3000), 64'd1);
    repeat (5) @(negedge hash_clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int snap;

    // Reset values
    #2 reset_n = 1'b0;
    repeat (2) @(posedge hash_clk);
    #1;
    check("rst_send",   64'(send0),   64'd0);
    check("rst_golden", 64'(golden0), 64'd0);
    check("rst_count",  64'(count0),  64'd0);
    check("rst_ovf",    64'(ovf0),    64'd0);
    check("rst_drop",   64'(drop0),   64'd0);
    check("rst_last",   64'(last0),   64'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge hash_clk);
    #1;

    // Single strobe, latency and single send
    snap = n_send0;
    exp_q.push_back({5'd2, 32'hDEADBEEF});
    strobe(4'b0100, slice(2, 32'hDEADBEEF));
    check("lat_send_n0", 64'(send0), 64'd0);
    @(posedge hash_clk); #1;
    check("lat_send_n1",  64'(send0),  64'd0);
    check("lat_count_n1", 64'(count0), 64'd1);
    @(posedge hash_clk); #1;
    check("lat_send_n2",   64'(send0),   64'd1);
    check("lat_golden_n2", 64'(golden0), 64'hDEADBEEF);
    check("lat_last_n2",   64'(last0),   64'd2);
    check("lat_count_n2",  64'(count0),  64'd0);
    wait_drain("single");
    check("single_send_count", 64'(n_send0 - snap), 64'd1);
    check("single_count_end",  64'(count0),         64'd0);

    // All four at once, both arbitration modes
    do_reset();
    for (int s = 0; s < SLAVES; s++) begin
      exp_q.push_back({SID_W'(s), 32'h10 + 32'(s)});
      exp_q1.push_back({SID_W'(s), 32'h10 + 32'(s)});
    end
    new_nonces1 = 4'hF;
    strobe(4'hF, {32'h13, 32'h12, 32'h11, 32'h10});
    new_nonces1 = '0;
    wait_drain("all4");

    // FIFO full: excess stays pending, then one re-strobe is lost
    do_reset();
    hold_busy = 1'b1;
    @(negedge hash_clk); #1;
    for (int k = 0; k < 9; k++) begin
      if (k < 8) exp_q.push_back({SID_W'(k % 4), 32'hA000_0000 + 32'(k)});
      strobe(SLAVES'(1 << (k % 4)), slice(k % 4, 32'hA000_0000 + 32'(k)));
    end
    repeat (3) @(posedge hash_clk); #1;
    check("full_count", 64'(count0), 64'd8);
    check("full_drop",  64'(drop0),  64'd0);
    check("full_ovf",   64'(ovf0),   64'd0);
    exp_q.push_back({5'd0, 32'hB000_0000});
    strobe(4'b0001, slice(0, 32'hB000_0000));
    check("restrobe_drop", 64'(drop0), 64'd1);
    check("restrobe_ovf",  64'(ovf0),  64'd1);
    hold_busy = 1'b0;
    wait_drain("full");

    // Re-strobe on the grant cycle: both values are sent
    do_reset();
    exp_q.push_back({5'd1, 32'h0000_AAAA});
    exp_q.push_back({5'd1, 32'h0000_BBBB});
    strobe(4'b0010, slice(1, 32'h0000_AAAA));
    strobe(4'b0010, slice(1, 32'h0000_BBBB));
    wait_drain("grant_hit");
    check("grant_hit_drop", 64'(drop0), 64'd0);
    check("grant_hit_ovf",  64'(ovf0),  64'd0);

    // Reset while in REQ with three words still queued
    do_reset();
    model_en  = 1'b0;
    hold_busy = 1'b1;
    @(negedge hash_clk); #1;
    strobe(4'hF, {32'h53, 32'h52, 32'h51, 32'h50});
    repeat (6) @(posedge hash_clk); #1;
    check("req_prefill_count", 64'(count0), 64'd4);
    exp_q.push_back({5'd0, 32'h50});
    hold_busy = 1'b0;
    @(posedge hash_clk); #1;
    check("req_send",   64'(send0),   64'd1);
    check("req_count",  64'(count0),  64'd3);
    check("req_golden", 64'(golden0), 64'h50);
    @(negedge hash_clk); #2;
    snap = n_send0;
    reset_n = 1'b0;
    #1;
    check("abort_send_async",  64'(send0),  64'd0);
    check("abort_count_async", 64'(count0), 64'd0);
    @(negedge hash_clk);
    reset_n  = 1'b1;
    model_en = 1'b1;
    repeat (20) @(posedge hash_clk); #1;
    check("post_rst_send",   64'(send0),            64'd0);
    check("post_rst_golden", 64'(golden0),          64'd0);
    check("post_rst_last",   64'(last0),            64'd0);
    check("post_rst_count",  64'(count0),           64'd0);
    check("post_rst_sends",  64'(n_send0 - snap),   64'd0);
    check("post_rst_queue",  64'(exp_q.size()),     64'd0);

    // Saturating drop counter
    do_reset();
    hold_busy = 1'b1;
    @(negedge hash_clk); #1;
    snap = n_send0;
    strobe(4'hF, {32'h63, 32'h62, 32'h61, 32'h60});
    repeat (5) @(posedge hash_clk); #1;
    strobe(4'hF, {32'h67, 32'h66, 32'h65, 32'h64});
    repeat (5) @(posedge hash_clk); #1;
    check("sat_fill_count", 64'(count0), 64'd8);
    strobe(4'hF, {32'h6B, 32'h6A, 32'h69, 32'h68});
    check("sat_first_pending_drop", 64'(drop0), 64'd0);
    strobe(4'hF, {32'h6F, 32'h6E, 32'h6D, 32'h6C});
    check("sat_first_drops", 64'(drop0), 64'd4);
    check("sat_first_ovf",   64'(ovf0),  64'd1);
    for (int k = 0; k < 17499; k++) begin
      strobe(4'hF, {32'(k), 32'(k), 32'(k), 32'(k)});
    end
    check("sat_drop",  64'(drop0),          64'hFFFF);
    check("sat_ovf",   64'(ovf0),           64'd1);
    check("sat_count", 64'(count0),         64'd8);
    check("sat_sends", 64'(n_send0 - snap), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
